// File: rtl/i2c_target_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_pkg
//  Description : Shared types and constants for the I2C register target.
//                - i2c_tgt_state_t : protocol FSM state encoding
//                - I2C_ACK / I2C_NACK : SDA level of the acknowledge bit
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_BYTE  = 3'd3,
        WR_ACK   = 3'd4,
        RD_BYTE  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage : i2c_target_pkg
`default_nettype wire

// File: rtl/i2c_bus_cond_detect.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_cond_detect
//  Description : Synchronises SCL/SDA into the clk domain and flags SCL edges
//                and START/STOP conditions.
//  Ports       : clk_i, rst_i (async, active high)
//                scl_i, sda_i        raw bus levels
//                scl_rise, scl_fall  one-cycle SCL edge strobes
//                start_det, stop_det one-cycle bus condition strobes
//                sda_s               synchronised SDA level
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_cond_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       scl_s;

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Reset to the idle-bus level so no spurious edge appears after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    // SCL must be high on both samples so an SDA change that coincides with
    // an SCL fall is treated as data, not as a bus condition.
    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

endmodule : i2c_bus_cond_detect
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_regs
//  Description : I2C target with a MEM_DEPTH x 8 register file addressed by
//                an auto-incrementing pointer. Open-drain SDA responder,
//                never stretches SCL.
//  Ports       : clk_i, rst_i (async, active high)
//                scl_i, sda_i      bus inputs
//                scl_o (always 1), sda_o (0 = pull low, 1 = release)
//                busy_o            addressed and inside a transaction
//                wr_valid_o/wr_index_o/wr_data_o  register write strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h22,
    parameter int         MEM_DEPTH   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         scl_i,
    input  logic                         sda_i,
    output logic                         scl_o,
    output logic                         sda_o,
    output logic                         busy_o,
    output logic                         wr_valid_o,
    output logic [$clog2(MEM_DEPTH)-1:0] wr_index_o,
    output logic [7:0]                   wr_data_o
);

    localparam int PTR_W = $clog2(MEM_DEPTH);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_cond_detect u_cond (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_tgt_state_t   state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic             ptr_byte_q, ptr_byte_d;   // next write byte loads ptr
    logic             ack_phase_q, ack_phase_d; // ACK bit currently driven
    logic             sda_q, sda_d;
    logic             busy_q, busy_d;
    logic             wr_valid_q, wr_valid_d;
    logic [PTR_W-1:0] wr_index_q, wr_index_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             mem_we;
    logic [7:0]       mem_q [MEM_DEPTH];

    logic [7:0] rx_byte;
    logic       byte_done;

    assign rx_byte   = {shift_q[6:0], sda_s};
    assign byte_done = scl_rise && (bit_cnt_q == 3'd7);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ADDR;
        end else if (stop_det) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDR:     if (byte_done)
                              state_d = (rx_byte[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall && ack_phase_q)
                              state_d = rw_q ? RD_BYTE : WR_BYTE;
                WR_BYTE:  if (byte_done) state_d = WR_ACK;
                WR_ACK:   if (scl_fall && ack_phase_q) state_d = WR_BYTE;
                RD_BYTE:  if (byte_done) state_d = RD_ACK;
                RD_ACK:   if (scl_rise)
                              state_d = (sda_s == I2C_NACK) ? IGNORE : RD_BYTE;
                default:  state_d = state_q;
            endcase
        end
    end

    // ------------------------------------------------- datapath and outputs
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        ptr_byte_d  = ptr_byte_q;
        ack_phase_d = ack_phase_q;
        sda_d       = sda_q;
        busy_d      = busy_q;
        wr_valid_d  = 1'b0;
        wr_index_d  = wr_index_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;

        if (start_det) begin
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            sda_d       = 1'b1;
        end else if (stop_det) begin
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            sda_d       = 1'b1;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == TARGET_ADDR) begin
                                busy_d      = 1'b1;
                                rw_d        = rx_byte[0];
                                ptr_byte_d  = 1'b1;
                                ack_phase_d = 1'b0;
                            end else begin
                                busy_d = 1'b0;
                            end
                        end
                    end
                end
                // First fall after the byte starts the ACK drive; the second
                // fall ends it (and presents the first read bit if reading).
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_d       = I2C_ACK;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            sda_d       = 1'b1;
                            if (state_q == ADDR_ACK && rw_q) begin
                                sda_d   = mem_q[ptr_q][7];
                                shift_d = {mem_q[ptr_q][6:0], 1'b0};
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (ptr_byte_q) begin
                                ptr_d      = rx_byte[PTR_W-1:0];
                                ptr_byte_d = 1'b0;
                            end else begin
                                mem_we     = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_index_d = ptr_q;
                                wr_data_d  = rx_byte;
                                ptr_d      = ptr_q + 1'b1;
                            end
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) ptr_d = ptr_q + 1'b1;
                    end else if (scl_fall) begin
                        sda_d   = shift_q[7];
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        sda_d = 1'b1;
                    end else if (scl_rise && sda_s == I2C_ACK) begin
                        shift_d = mem_q[ptr_q];
                    end
                end
                default: sda_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            ptr_byte_q  <= 1'b0;
            ack_phase_q <= 1'b0;
            sda_q       <= 1'b1;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_index_q  <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            ptr_byte_q  <= ptr_byte_d;
            ack_phase_q <= ack_phase_d;
            sda_q       <= sda_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            wr_index_q  <= wr_index_d;
            wr_data_q   <= wr_data_d;
            if (mem_we) mem_q[ptr_q] <= rx_byte;
        end
    end

    assign scl_o      = 1'b1;
    assign sda_o      = sda_q;
    assign busy_o     = busy_q;
    assign wr_valid_o = wr_valid_q;
    assign wr_index_o = wr_index_q;
    assign wr_data_o  = wr_data_q;

endmodule : i2c_target_regs
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target_regs
//  Description : Directed bench for i2c_target_regs. A simple I2C master
//                drives the open-drain bus; register writes are checked by a
//                scoreboard monitor, read data against expected queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regs;
    import i2c_target_pkg::*;

    localparam int HALF = 200;   // SCL half period in ns
    localparam int Q    = 100;   // quarter period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_o, sda_o, busy_o, wr_valid_o;
    logic [3:0] wr_index_o;
    logic [7:0] wr_data_o;
    logic       scl_bus, sda_bus;

    assign scl_bus = scl_m & scl_o;
    assign sda_bus = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_target_regs #(.TARGET_ADDR(7'h22), .MEM_DEPTH(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (scl_bus),
        .sda_i      (sda_bus),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .busy_o     (busy_o),
        .wr_valid_o (wr_valid_o),
        .wr_index_o (wr_index_o),
        .wr_data_o  (wr_data_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------ write scoreboard
    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
    } wr_t;
    wr_t wr_q[$];
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (wr_valid_o) begin
            check("wr_pulse_single_cycle", {31'd0, prev_valid}, 32'd0);
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got index 0x%0h data 0x%0h, expected no write",
                         wr_index_o, wr_data_o);
            end else begin
                check("wr_index", {28'd0, wr_index_o}, {28'd0, wr_q[0].idx});
                check("wr_data",  {24'd0, wr_data_o},  {24'd0, wr_q[0].data});
                void'(wr_q.pop_front());
            end
        end
        prev_valid <= wr_valid_o;
    end

    // --------------------------------------------------------- I2C master
    task automatic bus_start();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic bus_rstart();
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #HALF;
    endtask

    task automatic write_bit(input logic b);
        #Q sda_m = b;
        #Q scl_m = 1'b1;
        #HALF scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q b = sda_bus;
        #Q scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(master_ack);
    endtask

    // Writes one byte and checks the ACK bit seen on the bus.
    task automatic wr_and_check(input string name, input logic [7:0] v, input logic exp_ack);
        logic a;
        write_byte(v, a);
        check(name, {31'd0, a}, {31'd0, exp_ack});
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ stimulus
    logic [7:0] rd_exp_q[$];
    logic [7:0] rd_data;

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_scl_o",      {31'd0, scl_o},      32'd1);
        check("rst_sda_o",      {31'd0, sda_o},      32'd1);
        check("rst_busy_o",     {31'd0, busy_o},     32'd0);
        check("rst_wr_valid_o", {31'd0, wr_valid_o}, 32'd0);
        check("rst_wr_index_o", {28'd0, wr_index_o}, 32'd0);
        check("rst_wr_data_o",  {24'd0, wr_data_o},  32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);

        // Write 0xA5, 0x5A starting at register 3
        bus_start();
        wr_and_check("t1_addr_ack", 8'h44, I2C_ACK);
        check("t1_busy", {31'd0, busy_o}, 32'd1);
        wr_and_check("t1_ptr_ack", 8'h03, I2C_ACK);
        wr_q.push_back('{idx: 4'd3, data: 8'hA5});
        wr_and_check("t1_d0_ack", 8'hA5, I2C_ACK);
        wr_q.push_back('{idx: 4'd4, data: 8'h5A});
        wr_and_check("t1_d1_ack", 8'h5A, I2C_ACK);
        bus_stop();
        check("t1_busy_after_stop", {31'd0, busy_o}, 32'd0);
        check("t1_mem3", {24'd0, dut.mem_q[3]}, 32'hA5);
        check("t1_mem4", {24'd0, dut.mem_q[4]}, 32'h5A);

        // Pointer write, repeated START, read two bytes
        bus_start();
        wr_and_check("t2_addr_ack", 8'h44, I2C_ACK);
        wr_and_check("t2_ptr_ack", 8'h03, I2C_ACK);
        bus_rstart();
        wr_and_check("t2_raddr_ack", 8'h45, I2C_ACK);
        rd_exp_q.push_back(8'hA5);
        rd_exp_q.push_back(8'h5A);
        read_byte(I2C_ACK, rd_data);
        check("t2_rd0", {24'd0, rd_data}, {24'd0, rd_exp_q.pop_front()});
        read_byte(I2C_NACK, rd_data);
        check("t2_rd1", {24'd0, rd_data}, {24'd0, rd_exp_q.pop_front()});
        #Q check("t2_sda_released", {31'd0, sda_o}, 32'd1);
        bus_stop();
        check("t2_ptr", {28'd0, dut.ptr_q}, 32'd5);

        // Address mismatch
        bus_start();
        wr_and_check("t3_addr_nack", 8'h46, I2C_NACK);
        check("t3_busy", {31'd0, busy_o}, 32'd0);
        wr_and_check("t3_data_nack", 8'h77, I2C_NACK);
        bus_stop();

        // Pointer wrap 15 -> 0
        bus_start();
        wr_and_check("t4_addr_ack", 8'h44, I2C_ACK);
        wr_and_check("t4_ptr_ack", 8'h0F, I2C_ACK);
        wr_q.push_back('{idx: 4'd15, data: 8'h11});
        wr_and_check("t4_d0_ack", 8'h11, I2C_ACK);
        wr_q.push_back('{idx: 4'd0, data: 8'h22});
        wr_and_check("t4_d1_ack", 8'h22, I2C_ACK);
        bus_stop();
        check("t4_mem15", {24'd0, dut.mem_q[15]}, 32'h11);
        check("t4_mem0",  {24'd0, dut.mem_q[0]},  32'h22);
        check("t4_ptr",   {28'd0, dut.ptr_q},     32'd1);

        // STOP after 4 data bits
        bus_start();
        wr_and_check("t5_addr_ack", 8'h44, I2C_ACK);
        wr_and_check("t5_ptr_ack", 8'h06, I2C_ACK);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        bus_stop();
        check("t5_state_idle", {29'd0, dut.state_q}, {29'd0, IDLE});
        check("t5_mem6", {24'd0, dut.mem_q[6]}, 32'h00);
        check("t5_ptr",  {28'd0, dut.ptr_q},    32'd6);
        check("t5_busy", {31'd0, busy_o},       32'd0);

        // Reset while the target drives bit 7 (0) of 0x5A
        bus_start();
        wr_and_check("t6_addr_ack", 8'h44, I2C_ACK);
        wr_and_check("t6_ptr_ack", 8'h04, I2C_ACK);
        bus_rstart();
        wr_and_check("t6_raddr_ack", 8'h45, I2C_ACK);
        #Q check("t6_sda_driven_low", {31'd0, sda_o}, 32'd0);
        #3 rst = 1'b1;
        #1 check("t6_sda_released_on_reset", {31'd0, sda_o}, 32'd1);
        check("t6_mem3", {24'd0, dut.mem_q[3]}, 32'h00);
        check("t6_mem4", {24'd0, dut.mem_q[4]}, 32'h00);
        check("t6_ptr",  {28'd0, dut.ptr_q},    32'd0);
        check("t6_busy", {31'd0, busy_o},       32'd0);
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #HALF;
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);

        check("sb_all_writes_seen", wr_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_i2c_target_regs
`default_nettype wire
